// File: rtl/gauss_pkg.sv
// Shared constants and kernel helpers for the streaming binomial blur.
package gauss_pkg;

    localparam int STAGES = 32'sd3;

    // Binomial row coefficient for a given kernel size and tap position.
    function automatic int binom_weight(input int ksize, input int tap);
        int w;
        w = 32'sd0;
        case (ksize)
            32'sd3: begin
                case (tap)
                    32'sd0, 32'sd2: w = 32'sd1;
                    32'sd1:         w = 32'sd2;
                    default:        w = 32'sd0;
                endcase
            end
            32'sd5: begin
                case (tap)
                    32'sd0, 32'sd4: w = 32'sd1;
                    32'sd1, 32'sd3: w = 32'sd4;
                    32'sd2:         w = 32'sd6;
                    default:        w = 32'sd0;
                endcase
            end
            default: w = 32'sd0;
        endcase
        return w;
    endfunction

    function automatic int rowsum_log2(input int ksize);
        int r;
        case (ksize)
            32'sd3:  r = 32'sd2;
            32'sd5:  r = 32'sd4;
            default: r = 32'sd0;
        endcase
        return r;
    endfunction

    function automatic logic ksize_legal(input int ksize);
        return (ksize == 32'sd3) || (ksize == 32'sd5);
    endfunction

endpackage

// File: rtl/linebuf_ram.sv
// Simple dual-port line store with registered read; a same-address
// read during a write returns the previous contents.
module linebuf_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port and registered read port share one process so the read sees old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/gauss_blur_stream.sv
// Streaming KSIZE x KSIZE binomial blur / centre-pixel bypass over a
// line-buffered window, three pipeline stages from input beat to output.
module gauss_blur_stream
    import gauss_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3,
    parameter int LINE_W   = 640,
    parameter int COL_W    = 10,
    parameter int KSIZE    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic [COL_W-1:0]             col,
    input  logic [CHANNELS*DATA_W-1:0]   pix_in,
    input  logic                         filt_sel,
    output logic                         out_valid,
    output logic                         out_win_ok,
    output logic [CHANNELS*DATA_W-1:0]   out_pix
);

    localparam int RL2   = rowsum_log2(KSIZE);
    localparam int VS_W  = DATA_W + RL2;
    localparam int HS_W  = DATA_W + 2 * RL2;
    localparam int NRAM  = KSIZE - 1;
    localparam int CT    = (KSIZE - 1) / 2;
    localparam int PIX_W = CHANNELS * DATA_W;

    localparam logic [COL_W:0]   LINE_END = (COL_W + 1)'(LINE_W);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);
    localparam logic [COL_W-1:0] WIN_COL  = COL_W'(KSIZE - 1);
    localparam logic [2:0]       LC_MAX   = 3'(KSIZE - 1);
    localparam logic [HS_W-1:0]  RND      = HS_W'(1'b1) << (2 * RL2 - 1);

    if (!ksize_legal(KSIZE)) begin : g_bad_ksize
        $error("gauss_blur_stream: KSIZE must be 3 or 5");
    end

    logic                accept_s;
    logic                line_end_s;
    logic                win_s;
    logic [2:0]          line_s;
    logic [2:0]          lc_r;

    logic                s1_valid_r;
    logic                s1_filt_r;
    logic                s1_win_r;
    logic [COL_W-1:0]    s1_col_r;
    logic [PIX_W-1:0]    s1_pix_r;

    logic [DATA_W-1:0]   rd_s   [CHANNELS][NRAM];
    logic [DATA_W-1:0]   tap_s  [CHANNELS][KSIZE];
    logic [VS_W-1:0]     vsum_s [CHANNELS];

    logic                s2_valid_r;
    logic                s2_filt_r;
    logic                s2_win_r;
    logic [VS_W-1:0]     hsr_r  [CHANNELS][KSIZE];
    logic [DATA_W-1:0]   cen_r  [CHANNELS][KSIZE];

    logic [HS_W-1:0]     hsum_s [CHANNELS];
    logic [PIX_W-1:0]    res_s;

    // Beat qualification and the line index this beat belongs to.
    always_comb begin
        accept_s   = in_valid && ({1'b0, col} < LINE_END);
        line_s     = in_sof ? 3'd0 : lc_r;
        line_end_s = (col == LAST_COL);
        win_s      = (line_s >= LC_MAX) && (col >= WIN_COL);
    end

    // Line counter: an accepted in_sof restarts it, end of line advances and saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            lc_r <= 3'd0;
        end else if (accept_s) begin
            if (line_end_s) begin
                lc_r <= (line_s >= LC_MAX) ? LC_MAX : line_s + 3'd1;
            end else begin
                lc_r <= line_s;
            end
        end
    end

    // S1: capture the beat alongside the registered RAM reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_filt_r  <= 1'b0;
            s1_win_r   <= 1'b0;
            s1_col_r   <= {COL_W{1'b0}};
            s1_pix_r   <= {PIX_W{1'b0}};
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_filt_r <= filt_sel;
                s1_win_r  <= win_s;
                s1_col_r  <= col;
                s1_pix_r  <= pix_in;
            end
        end
    end

    // Chain writes land one cycle after the read, once the older line's data is out of RAMn-1.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        for (genvar r = 0; r < NRAM; r++) begin : g_ram
            logic [DATA_W-1:0] wdata_s;
            if (r == 0) begin : g_first
                assign wdata_s = s1_pix_r[ch*DATA_W +: DATA_W];
            end else begin : g_next
                assign wdata_s = rd_s[ch][r-1];
            end
            linebuf_ram #(
                .DATA_W (DATA_W),
                .DEPTH  (LINE_W),
                .ADDR_W (COL_W)
            ) u_ram (
                .clk   (clk),
                .we    (s1_valid_r),
                .waddr (s1_col_r),
                .wdata (wdata_s),
                .re    (accept_s),
                .raddr (col),
                .rdata (rd_s[ch][r])
            );
        end
    end

    // Vertical taps (newest line first) and their weighted sum.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            tap_s[ch][0] = s1_pix_r[ch*DATA_W +: DATA_W];
            for (int k = 1; k < KSIZE; k++) begin
                tap_s[ch][k] = rd_s[ch][k-1];
            end
            vsum_s[ch] = {VS_W{1'b0}};
            for (int k = 0; k < KSIZE; k++) begin
                vsum_s[ch] = vsum_s[ch] + VS_W'(tap_s[ch][k]) * VS_W'(binom_weight(KSIZE, k));
            end
        end
    end

    // S2: horizontal shift of vertical sums and centre pixels, valid beats only.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_filt_r  <= 1'b0;
            s2_win_r   <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                for (int k = 0; k < KSIZE; k++) begin
                    hsr_r[ch][k] <= {VS_W{1'b0}};
                    cen_r[ch][k] <= {DATA_W{1'b0}};
                end
            end
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_filt_r  <= s1_filt_r;
            s2_win_r   <= s1_win_r;
            if (s1_valid_r) begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    hsr_r[ch][0] <= vsum_s[ch];
                    cen_r[ch][0] <= tap_s[ch][CT];
                    for (int k = 1; k < KSIZE; k++) begin
                        hsr_r[ch][k] <= hsr_r[ch][k-1];
                        cen_r[ch][k] <= cen_r[ch][k-1];
                    end
                end
            end
        end
    end

    // Horizontal weighted sum with round-half-up, or the window centre in bypass.
    always_comb begin
        res_s = {PIX_W{1'b0}};
        for (int ch = 0; ch < CHANNELS; ch++) begin
            hsum_s[ch] = RND;
            for (int k = 0; k < KSIZE; k++) begin
                hsum_s[ch] = hsum_s[ch] + HS_W'(hsr_r[ch][k]) * HS_W'(binom_weight(KSIZE, k));
            end
            res_s[ch*DATA_W +: DATA_W] = s2_filt_r ? hsum_s[ch][HS_W-1 -: DATA_W] : cen_r[ch][CT];
        end
    end

    // S3: output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_win_ok <= 1'b0;
            out_pix    <= {PIX_W{1'b0}};
        end else begin
            out_valid  <= s2_valid_r;
            out_win_ok <= s2_valid_r & s2_win_r;
            if (s2_valid_r) begin
                out_pix <= res_s;
            end
        end
    end

endmodule
